// File: rtl/light_phase_if.sv
// Signal bundle between the intersection sensors/button and the phase scheduler.
// The flash input exists only when LIGHT_FLASH_EN is defined.
interface light_phase_if;
  logic       veh_ew;
  logic       veh_sn;
  logic       ped_req;
`ifdef LIGHT_FLASH_EN
  logic       flash;
`endif
  logic [1:0] e_west;
  logic [1:0] s_north;
  logic       ped_walk;
  logic [2:0] phase;

  modport master (
`ifdef LIGHT_FLASH_EN
    output flash,
`endif
    output veh_ew, veh_sn, ped_req,
    input  e_west, s_north, ped_walk, phase
  );

  modport slave (
`ifdef LIGHT_FLASH_EN
    input  flash,
`endif
    input  veh_ew, veh_sn, ped_req,
    output e_west, s_north, ped_walk, phase
  );
endinterface

// File: rtl/light_phase_sched.sv
// Demand-driven two-way intersection phase scheduler with pedestrian walk interval.
// Optional flashing-yellow mode is compiled in with LIGHT_FLASH_EN.
module light_phase_sched #(
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 25,
  parameter int unsigned YELLOW_T  = 5,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned PED_T     = 8
) (
  input logic           clk,
  input logic           rst,
  light_phase_if.slave  bus
);

  typedef enum logic [2:0] {
    EW_G = 3'd0,
    EW_Y = 3'd1,
    AR1  = 3'd2,
    SN_G = 3'd3,
    SN_Y = 3'd4,
    AR2  = 3'd5,
    PED  = 3'd6
`ifdef LIGHT_FLASH_EN
    , FLASH = 3'd7
`endif
  } state_t;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] GRN = 2'b01;
  localparam logic [1:0] YEL = 2'b10;
  localparam logic       DIR_SN = 1'b1;
  localparam logic       DIR_EW = 1'b0;

  localparam logic [7:0] GMIN_L = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_L = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_L  = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_L   = 8'(ALLRED_T - 1);
  localparam logic [7:0] PED_L  = 8'(PED_T - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       ped_pend, ped_nx;
  logic       nxt_dir, dir_nx;
  logic       cmp;

  logic [1:0] e_west_r, s_north_r;
  logic       ped_walk_r;
  logic [2:0] phase_r;

  // Head/lamp pattern {e_west, s_north, ped_walk} for a state and its counter.
  function automatic logic [4:0] heads(input state_t s, input logic [7:0] c);
    logic [4:0] h;
    h = {RED, RED, 1'b0};
    case (s)
      EW_G:    h[4:3] = GRN;
      EW_Y:    h[4:3] = YEL;
      SN_G:    h[2:1] = GRN;
      SN_Y:    h[2:1] = YEL;
      PED:     h[0]   = 1'b1;
`ifdef LIGHT_FLASH_EN
      FLASH:   if (!c[2]) h = {YEL, YEL, 1'b0};
`endif
      default: h = {RED, RED, 1'b0};
    endcase
    return h;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hff) ? c : c + 8'd1;
  endfunction

  always_comb begin
    state_nx = state;
    ped_nx   = ped_pend | bus.ped_req;
    dir_nx   = nxt_dir;
    cmp      = 1'b0;
    case (state)
      EW_G: begin
        cmp = bus.veh_sn | ped_pend;
        if (cnt >= GMIN_L && cmp && (!bus.veh_ew || cnt >= GMAX_L)) state_nx = EW_Y;
      end
      EW_Y: if (cnt == YEL_L) state_nx = AR1;
      AR1: if (cnt == AR_L) begin
        dir_nx   = DIR_SN;
        state_nx = ped_pend ? PED : SN_G;
      end
      SN_G: begin
        cmp = bus.veh_ew | ped_pend;
        if (cnt >= GMIN_L && cmp && (!bus.veh_sn || cnt >= GMAX_L)) state_nx = SN_Y;
      end
      SN_Y: if (cnt == YEL_L) state_nx = AR2;
      AR2: if (cnt == AR_L) begin
        dir_nx   = DIR_EW;
        state_nx = ped_pend ? PED : EW_G;
      end
      PED: if (cnt == PED_L) state_nx = (nxt_dir == DIR_SN) ? SN_G : EW_G;
`ifdef LIGHT_FLASH_EN
      FLASH: if (!bus.flash) state_nx = AR2;
`endif
      default: state_nx = EW_G;
    endcase
`ifdef LIGHT_FLASH_EN
    if (bus.flash) state_nx = FLASH;
`endif
    // A request on the very edge that enters PED is served by that walk.
    if (state_nx == PED && state != PED) ped_nx = 1'b0;

    if (state_nx != state) cnt_nx = 8'd0;
`ifdef LIGHT_FLASH_EN
    else if (state == FLASH) cnt_nx = {5'd0, cnt[2:0] + 3'd1};
`endif
    else cnt_nx = sat_inc(cnt);
  end

  // Single registered stage: state, counters and decoded heads update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EW_G;
      cnt        <= 8'd0;
      ped_pend   <= 1'b0;
      nxt_dir    <= DIR_SN;
      e_west_r   <= GRN;
      s_north_r  <= RED;
      ped_walk_r <= 1'b0;
      phase_r    <= 3'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ped_pend   <= ped_nx;
      nxt_dir    <= dir_nx;
      {e_west_r, s_north_r, ped_walk_r} <= heads(state_nx, cnt_nx);
      phase_r    <= state_nx;
    end
  end

  assign bus.e_west   = e_west_r;
  assign bus.s_north  = s_north_r;
  assign bus.ped_walk = ped_walk_r;
  assign bus.phase    = phase_r;

endmodule
